// File: rtl/im_loader.sv
// Serial-stream instruction-memory loader: length header, big-endian words, CPU held in reset until done.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module im_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WR,
        CHK,
        DONE,
        ERR
    } state_t;

    // Word counts above the memory depth abort the load.
    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHK;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t      state;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [16:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] word_sr;
    logic        accept;
    logic        load_start;

    assign byte_ready = (state == LEN_HI) || (state == LEN_LO) ||
                        (state == DATA)   || (state == CHK);
    assign accept     = byte_valid && byte_ready;
    assign load_start = start && ((state == IDLE) || (state == DONE) || (state == ERR));

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] chk;

    // Running XOR over every header and data byte; the trailing byte itself is excluded.
    always_ff @(posedge clk) begin
        if (rst || load_start) begin
            chk <= 8'd0;
        end else if (accept && (state != CHK)) begin
            chk <= chk ^ byte_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= 32'd0;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            len_hi   <= 8'd0;
            len      <= 16'd0;
            word_idx <= 17'd0;
            byte_cnt <= 2'd0;
            word_sr  <= 24'd0;
        end else begin
            im_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= LEN_HI;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_rst  <= 1'b1;
                        word_idx <= 17'd0;
                        byte_cnt <= 2'd0;
                    end else if (state == DONE) begin
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                    end else if (state == ERR) begin
                        err <= 1'b1;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len_hi <= byte_data;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len <= {len_hi, byte_data};
                        if ({16'd0, len_hi, byte_data} > DEPTH) begin
                            state <= ERR;
                        end else if ({len_hi, byte_data} == 16'd0) begin
                            state <= END_STATE;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    // First byte of a word lands in the top lane; the 4th byte issues the write.
                    if (accept) begin
                        word_sr  <= {word_sr[15:0], byte_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state    <= WR;
                            im_we    <= 1'b1;
                            im_addr  <= ADDR_W'(word_idx);
                            im_wdata <= {word_sr, byte_data};
                        end
                    end
                end
                WR: begin
                    word_idx <= word_idx + 17'd1;
                    if ((word_idx + 17'd1) < {1'b0, len}) begin
                        state <= DATA;
                    end else begin
                        state <= END_STATE;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (accept) begin
                        state <= (byte_data == chk) ? DONE : ERR;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Randomized scoreboard bench for im_loader; a stream-level model predicts writes and final outcome.
`timescale 1ns/1ps
module tb_im_loader;

    localparam int ADDR_W = 8;

    typedef logic [7:0] u8;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    im_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];
    logic prev_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe pops one predicted write.
    always @(negedge clk) begin
        if (im_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", im_addr, im_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(im_addr), 32'(e.addr));
                check("wr_data", im_wdata, e.data);
                check("ready_during_wr", 32'(byte_ready), 32'd0);
            end
            check("we_single_cycle", 32'(prev_we), 32'd0);
        end
        if (done && err) begin
            checks++;
            errors++;
            $display("FAIL done_and_err: got done=1 err=1, expected at most one");
        end
        prev_we <= im_we;
    end

    // Reference: N from the header, words in stream order, XOR of everything before the trailer.
    task automatic model(input u8 s[$], output bit exp_err);
        int n;
        n = int'(s[0]) * 256 + int'(s[1]);
        exp_err = 1'b0;
        if (n > (1 << ADDR_W)) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            wr_t w;
            w.addr = ADDR_W'(i);
            w.data = {s[2 + 4*i], s[3 + 4*i], s[4 + 4*i], s[5 + 4*i]};
            exp_q.push_back(w);
        end
`ifdef LOADER_CHECKSUM_EN
        begin
            u8 x;
            x = 8'd0;
            for (int j = 0; j < 2 + 4*n; j++) x = x ^ s[j];
            exp_err = (s[2 + 4*n] != x);
        end
`endif
    endtask

    task automatic append_chk(inout u8 s[$], input bit corrupt);
`ifdef LOADER_CHECKSUM_EN
        u8 x;
        x = 8'd0;
        foreach (s[j]) x = x ^ s[j];
        s.push_back(corrupt ? (x ^ 8'h5A) : x);
`else
        if (corrupt) s.push_back(8'h00);
`endif
    endtask

    task automatic make_stream(input int n, input bit corrupt, output u8 s[$]);
        s.delete();
        s.push_back(u8'(n >> 8));
        s.push_back(u8'(n & 255));
        for (int i = 0; i < 4*n; i++) s.push_back(u8'($urandom));
        append_chk(s, corrupt);
    endtask

    // gap_mode: 0 = continuous, 1 = valid toggles each cycle, 2 = random bubbles.
    task automatic drive(input u8 s[$], input int gap_mode, input bit noise);
        foreach (s[i]) begin
            int  waited;
            bit  taken;
            waited = 0;
            taken  = 1'b0;
            while (!taken) begin
                @(negedge clk);
                case (gap_mode)
                    0:       byte_valid = 1'b1;
                    1:       byte_valid = ~byte_valid;
                    default: byte_valid = ($urandom_range(0, 2) != 0);
                endcase
                byte_data = byte_valid ? s[i] : u8'($urandom);
                start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                taken     = byte_valid && byte_ready;
                waited++;
                if (waited > 64) begin
                    checks++;
                    errors++;
                    $display("FAIL byte_stall: byte %0d not accepted within 64 cycles, expected acceptance", i);
                    byte_valid = 1'b0;
                    start      = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_cpu_rst", 32'(cpu_rst), 32'd1);
        check("load_done_clr", 32'(done), 32'd0);
        check("load_err_clr", 32'(err), 32'd0);
    endtask

    task automatic run_load(input u8 s[$], input int gap_mode, input bit noise);
        bit exp_err;
        int n;
        model(s, exp_err);
        pulse_start();
        drive(s, gap_mode, noise);
        n = 0;
        while (!(done || err) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("end_done", 32'(done), 32'(!exp_err));
        check("end_err", 32'(err), 32'(exp_err));
        check("end_cpu_rst", 32'(cpu_rst), 32'(exp_err));
        check("writes_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic reset_checks();
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_im_we", 32'(im_we), 32'd0);
        check("rst_im_addr", 32'(im_addr), 32'd0);
        check("rst_im_wdata", im_wdata, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        u8 s[$];
        u8 fx[6];
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        repeat (3) @(negedge clk);
        reset_checks();
        rst = 1'b0;

        // Single word 0x3408000A.
        fx = '{8'h00, 8'h01, 8'h34, 8'h08, 8'h00, 8'h0A};
        s.delete();
        foreach (fx[i]) s.push_back(fx[i]);
        append_chk(s, 1'b0);
        run_load(s, 0, 1'b0);

        // Three words with valid toggling every cycle.
        make_stream(3, 1'b0, s);
        run_load(s, 1, 1'b0);

        // N = 257 overflows a 256-word memory: header only.
        s.delete();
        s.push_back(8'h01);
        s.push_back(8'h01);
        run_load(s, 0, 1'b0);

        // N = 0.
        make_stream(0, 1'b0, s);
        run_load(s, 2, 1'b0);

        // Reset after two data bytes, then a clean reload from address 0.
        pulse_start();
        s.delete();
        s.push_back(8'h00);
        s.push_back(8'h01);
        s.push_back(8'hAA);
        s.push_back(8'hBB);
        drive(s, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        reset_checks();
        rst = 1'b0;
        make_stream(2, 1'b0, s);
        run_load(s, 2, 1'b0);

        // Largest legal load fills every address.
        make_stream(1 << ADDR_W, 1'b0, s);
        run_load(s, 0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        s.delete();
        foreach (fx[i]) s.push_back(fx[i]);
        append_chk(s, 1'b1);
        run_load(s, 0, 1'b0);
`endif

        // Random loads with bubbles and start asserted mid-load.
        for (int k = 0; k < 8; k++) begin
            make_stream($urandom_range(1, 6), 1'b0, s);
            run_load(s, 2, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
